controlador_contador: RTL and testbench

CONTROLADOR_CONTADOR -- requirements
Module: controlador_contador

---
 rtl/controlador_contador_if.sv | 23 ++
 rtl/controlador_contador.sv | 168 ++++++++++++++++
 tb/tb_controlador_contador.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_contador_if.sv
// Button/mode inputs and step/status outputs of the counter controller.
// The bench (master) drives the raw buttons and mode bits; the controller (slave) answers.
interface controlador_contador_if;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic       AUTO;
    logic       ERRO_ACK;
    logic       STEP_UP;
    logic       STEP_DOWN;
    logic       ERRO;
    logic [3:0] VALOR;
    logic [1:0] MODO;

    modport master (
        output BTN_UP, BTN_DOWN, AUTO, ERRO_ACK,
        input  STEP_UP, STEP_DOWN, ERRO, VALOR, MODO
    );

    modport slave (
        input  BTN_UP, BTN_DOWN, AUTO, ERRO_ACK,
        output STEP_UP, STEP_DOWN, ERRO, VALOR, MODO
    );
endinterface

// File: rtl/controlador_contador.sv
// Counter controller: debounced up/down buttons in manual mode, a timed 0..MAX_VAL
// sweep in auto mode, and an error state entered on conflicting button presses.
module controlador_contador #(
    parameter int DEB_CICLOS = 4,
    parameter int TICK_DIV   = 10,
    parameter int MAX_VAL    = 8
) (
    input  logic                   clock_inicial,
    input  logic                   RESET,
    controlador_contador_if.slave  bus
);

    typedef enum logic [1:0] {
        MANUAL    = 2'b00,
        AUTO_UP   = 2'b01,
        AUTO_DOWN = 2'b10,
        ERRO_ST   = 2'b11
    } estado_t;

    localparam int              DW       = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
    localparam int              TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]   DEB_FIM  = DW'(DEB_CICLOS - 1);
    localparam logic [TW-1:0]   TICK_FIM = TW'(TICK_DIV - 1);
    localparam logic [3:0]      VAL_MAX  = 4'(MAX_VAL);

    // Index 0 = up button, index 1 = down button.
    logic [1:0]    btn_raw, sinc1, sinc2, deb, deb_ant, req;
    logic [DW-1:0] deb_cnt [2];

    estado_t       estado, estado_prox;
    logic [3:0]    valor, valor_prox, valor_auto;
    logic [TW-1:0] tick, tick_prox;
    logic          step_up, step_down, erro;
    logic          step_up_prox, step_down_prox;
    logic          req_up, req_down, nivel_up, nivel_down;
    logic          conflito, tick_fim, auto_sobe, erro_sai;

    assign btn_raw = {bus.BTN_DOWN, bus.BTN_UP};

    always_ff @(posedge clock_inicial) begin
        if (RESET) begin
            sinc1   <= '0;
            sinc2   <= '0;
            deb     <= '0;
            deb_ant <= '0;
            req     <= '0;
            for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sinc1   <= btn_raw;
            sinc2   <= sinc1;
            deb_ant <= deb;
            req     <= deb & ~deb_ant;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sinc2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_FIM) begin
                        deb[i]     <= sinc2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign req_up     = req[0];
    assign req_down   = req[1];
    assign nivel_up   = deb[0];
    assign nivel_down = deb[1];
    assign conflito   = (req_up & req_down) | (req_up & nivel_down) | (req_down & nivel_up);
    assign tick_fim   = (tick == TICK_FIM);
    assign erro_sai   = bus.ERRO_ACK & ~nivel_up & ~nivel_down;

    // Auto direction follows the state, but never steps past either end of the range.
    assign auto_sobe  = (estado == AUTO_UP) ? (valor != VAL_MAX) : (valor == '0);
    assign valor_auto = auto_sobe ? valor + 4'd1 : valor - 4'd1;

    always_ff @(posedge clock_inicial) begin
        if (RESET) begin
            estado    <= MANUAL;
            valor     <= '0;
            tick      <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            erro      <= 1'b0;
        end else begin
            estado    <= estado_prox;
            valor     <= valor_prox;
            tick      <= tick_prox;
            step_up   <= step_up_prox;
            step_down <= step_down_prox;
            erro      <= (estado_prox == ERRO_ST);
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            MANUAL: begin
                if (conflito)      estado_prox = ERRO_ST;
                else if (bus.AUTO) estado_prox = AUTO_UP;
            end
            AUTO_UP, AUTO_DOWN: begin
                if (conflito)       estado_prox = ERRO_ST;
                else if (!bus.AUTO) estado_prox = MANUAL;
                else if (tick_fim) begin
                    if (auto_sobe) estado_prox = (valor_auto == VAL_MAX) ? AUTO_DOWN : AUTO_UP;
                    else           estado_prox = (valor_auto == '0) ? AUTO_UP : AUTO_DOWN;
                end
            end
            ERRO_ST: begin
                if (erro_sai) estado_prox = MANUAL;
            end
            default: estado_prox = MANUAL;
        endcase
    end

    always_comb begin
        valor_prox     = valor;
        tick_prox      = tick;
        step_up_prox   = 1'b0;
        step_down_prox = 1'b0;
        case (estado)
            MANUAL: begin
                tick_prox = '0;
                if (!conflito && !bus.AUTO) begin
                    if (req_up) begin
                        step_up_prox = 1'b1;
                        valor_prox   = (valor == VAL_MAX) ? '0 : valor + 4'd1;
                    end else if (req_down) begin
                        step_down_prox = 1'b1;
                        valor_prox     = (valor == '0) ? VAL_MAX : valor - 4'd1;
                    end
                end
            end
            AUTO_UP, AUTO_DOWN: begin
                // Leaving auto mode still honours a step due on the same edge.
                if (!conflito) begin
                    if (tick_fim) begin
                        tick_prox      = '0;
                        valor_prox     = valor_auto;
                        step_up_prox   = auto_sobe;
                        step_down_prox = ~auto_sobe;
                    end else begin
                        tick_prox = tick + TW'(1);
                    end
                    if (!bus.AUTO) tick_prox = '0;
                end
            end
            ERRO_ST: begin
                if (erro_sai) begin
                    valor_prox     = '0;
                    step_down_prox = (valor != '0);
                end
            end
            default: ;
        endcase
    end

    assign bus.STEP_UP   = step_up;
    assign bus.STEP_DOWN = step_down;
    assign bus.ERRO      = erro;
    assign bus.VALOR     = valor;
    assign bus.MODO      = estado;

endmodule

// File: tb/tb_controlador_contador.sv
// Bench for controlador_contador: directed scenarios plus random stimulus, every cycle
// compared against a history-based reference model of the controller.
module tb_controlador_contador;

    localparam int DEB  = 4;
    localparam int TDIV = 10;
    localparam int VMAX = 8;
    localparam int NE   = 8192;

    logic clock_inicial = 1'b0;
    logic RESET;

    always #5 clock_inicial = ~clock_inicial;

    controlador_contador_if bus ();

    controlador_contador #(
        .DEB_CICLOS (DEB),
        .TICK_DIV   (TDIV),
        .MAX_VAL    (VMAX)
    ) dut (
        .clock_inicial (clock_inicial),
        .RESET         (RESET),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic confere(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-edge histories of synchronized samples and debounced levels.
    // A level flips when the last DEB synchronized samples all disagree with it.
    int e = 8;
    bit s1u, s1d;
    bit s2u [NE];
    bit s2d [NE];
    bit du  [NE];
    bit dd  [NE];
    bit rh  [NE];
    int m_modo, m_valor, m_tick;
    bit m_su, m_sd;
    bit ok_u, ok_d, ru, rd, lu, ld, conf, sobe;

    always @(posedge clock_inicial) begin
        if (e >= NE - 1) begin
            $display("FAIL model_history: got=%0d exp<%0d", e, NE - 1);
            $fatal(1, "history overflow");
        end
        e++;
        rh[e] = RESET;
        if (RESET) begin
            s1u = 0; s1d = 0;
            s2u[e] = 0; s2d[e] = 0;
            du[e] = 0; dd[e] = 0;
            m_modo = 0; m_valor = 0; m_tick = 0;
            m_su = 0; m_sd = 0;
        end else begin
            s2u[e] = s1u; s2d[e] = s1d;
            s1u = bus.BTN_UP; s1d = bus.BTN_DOWN;
            ok_u = 1; ok_d = 1;
            for (int j = 1; j <= DEB; j++) begin
                if (s2u[e-j] == du[e-1]) ok_u = 0;
                if (s2d[e-j] == dd[e-1]) ok_d = 0;
            end
            du[e] = ok_u ? !du[e-1] : du[e-1];
            dd[e] = ok_d ? !dd[e-1] : dd[e-1];

            ru = !rh[e-1] && du[e-2] && !du[e-3];
            rd = !rh[e-1] && dd[e-2] && !dd[e-3];
            lu = du[e-1];
            ld = dd[e-1];
            conf = (ru && rd) || (ru && ld) || (rd && lu);
            m_su = 0; m_sd = 0;

            if (m_modo == 0) begin
                if (conf) m_modo = 3;
                else if (bus.AUTO) begin m_modo = 1; m_tick = 0; end
                else if (ru) begin m_su = 1; m_valor = (m_valor == VMAX) ? 0 : m_valor + 1; end
                else if (rd) begin m_sd = 1; m_valor = (m_valor == 0) ? VMAX : m_valor - 1; end
            end else if (m_modo == 1 || m_modo == 2) begin
                if (conf) m_modo = 3;
                else begin
                    if (m_tick == TDIV - 1) begin
                        m_tick = 0;
                        sobe = (m_modo == 1) ? (m_valor < VMAX) : (m_valor == 0);
                        if (sobe) begin
                            m_valor++; m_su = 1;
                            m_modo = (m_valor == VMAX) ? 2 : 1;
                        end else begin
                            m_valor--; m_sd = 1;
                            m_modo = (m_valor == 0) ? 1 : 2;
                        end
                    end else begin
                        m_tick++;
                    end
                    if (!bus.AUTO) begin m_modo = 0; m_tick = 0; end
                end
            end else begin
                if (bus.ERRO_ACK && !lu && !ld) begin
                    m_sd = (m_valor != 0);
                    m_valor = 0;
                    m_modo = 0;
                end
            end
        end
    end

    task automatic ciclo();
        @(negedge clock_inicial);
        confere("step_up",   bus.STEP_UP,   m_su);
        confere("step_down", bus.STEP_DOWN, m_sd);
        confere("erro",      bus.ERRO,      (m_modo == 3) ? 1 : 0);
        confere("valor",     bus.VALOR,     m_valor);
        confere("modo",      bus.MODO,      m_modo);
    endtask

    task automatic espera(input int n);
        for (int i = 0; i < n; i++) ciclo();
    endtask

    task automatic aperta(input bit up, input int alto, input int baixo);
        if (up) bus.BTN_UP = 1; else bus.BTN_DOWN = 1;
        espera(alto);
        if (up) bus.BTN_UP = 0; else bus.BTN_DOWN = 0;
        espera(baixo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat, vista;
        RESET = 1;
        bus.BTN_UP = 0; bus.BTN_DOWN = 0; bus.AUTO = 0; bus.ERRO_ACK = 0;
        espera(3);
        confere("rst_valor", bus.VALOR, 0);
        confere("rst_modo",  bus.MODO,  0);
        confere("rst_steps", {bus.STEP_UP, bus.STEP_DOWN, bus.ERRO}, 0);
        RESET = 0;
        espera(2);

        // Clean press held 20 cycles: one step, 7 edges after first sample.
        bus.BTN_UP = 1;
        n = 0; lat = -1;
        for (int c = 0; c < 20; c++) begin
            ciclo();
            if (bus.STEP_UP) begin n++; if (lat < 0) lat = c; end
        end
        confere("hold_n_steps", n, 1);
        confere("hold_latency", lat, 7);
        bus.BTN_UP = 0;
        espera(10);
        confere("hold_valor", bus.VALOR, 1);

        // Wrap checks at the ends of the range.
        for (int k = 0; k < 7; k++) aperta(1, 10, 10);
        confere("up_to_max", bus.VALOR, VMAX);
        aperta(1, 10, 10);
        confere("wrap_up", bus.VALOR, 0);
        aperta(0, 10, 10);
        confere("wrap_down", bus.VALOR, VMAX);

        // Bounced press: 2-cycle glitches, then stable.
        n = 0;
        for (int g = 0; g < 4; g++) begin
            bus.BTN_UP = (g % 2 == 0);
            for (int c = 0; c < 2; c++) begin ciclo(); n += bus.STEP_UP; end
        end
        confere("bounce_glitch_steps", n, 0);
        bus.BTN_UP = 1;
        n = 0; lat = -1;
        for (int c = 0; c < 14; c++) begin
            ciclo();
            if (bus.STEP_UP) begin n++; if (lat < 0) lat = c; end
        end
        confere("bounce_n_steps", n, 1);
        confere("bounce_latency", lat, 7);
        bus.BTN_UP = 0;
        espera(10);
        confere("bounce_valor", bus.VALOR, 0);

        // Auto sweep for 200 cycles, then drop AUTO on a terminal tick.
        bus.AUTO = 1;
        n = 0; vista = 0;
        for (int c = 0; c < 200; c++) begin
            ciclo();
            n += bus.STEP_UP + bus.STEP_DOWN;
            if (bus.MODO == 2'b10) vista = 1;
        end
        confere("auto_steps", n, 19);
        confere("auto_saw_down", vista, 1);
        bus.AUTO = 0;
        ciclo();
        confere("auto_exit_step", bus.STEP_UP, 1);
        confere("auto_exit_valor", bus.VALOR, 4);
        confere("auto_exit_modo", bus.MODO, 0);
        espera(3);
        aperta(0, 10, 10);
        confere("pre_conflict_valor", bus.VALOR, 3);

        // Simultaneous press: error, held by buttons, cleared by ack after release.
        bus.BTN_UP = 1; bus.BTN_DOWN = 1;
        n = 0;
        for (int c = 0; c < 12; c++) begin ciclo(); n += bus.STEP_UP + bus.STEP_DOWN; end
        confere("conflict_erro", bus.ERRO, 1);
        confere("conflict_modo", bus.MODO, 3);
        confere("conflict_steps", n, 0);
        bus.ERRO_ACK = 1;
        espera(10);
        confere("ack_held_erro", bus.ERRO, 1);
        bus.BTN_UP = 0; bus.BTN_DOWN = 0;
        n = 0;
        for (int c = 0; c < 20; c++) begin ciclo(); n += bus.STEP_DOWN + bus.STEP_UP; end
        confere("ack_exit_modo", bus.MODO, 0);
        confere("ack_exit_valor", bus.VALOR, 0);
        confere("ack_exit_steps", n, 1);
        bus.ERRO_ACK = 0;
        espera(2);

        // Reset on the terminal tick of AUTO_DOWN.
        bus.AUTO = 1;
        vista = 0;
        for (int c = 0; c < 150 && !vista; c++) begin
            ciclo();
            if (bus.MODO == 2'b10) vista = 1;
        end
        confere("reach_auto_down", vista, 1);
        espera(9);
        RESET = 1;
        ciclo();
        confere("mid_tick_rst_steps", {bus.STEP_UP, bus.STEP_DOWN}, 0);
        confere("mid_tick_rst_valor", bus.VALOR, 0);
        confere("mid_tick_rst_modo", bus.MODO, 0);
        confere("mid_tick_rst_erro", bus.ERRO, 0);
        RESET = 0;
        bus.AUTO = 0;
        espera(3);

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(11) == 0) bus.BTN_UP   = ~bus.BTN_UP;
            if ($urandom_range(14) == 0) bus.BTN_DOWN = ~bus.BTN_DOWN;
            if ($urandom_range(59) == 0) bus.AUTO     = ~bus.AUTO;
            bus.ERRO_ACK = ($urandom_range(3) == 0);
            RESET        = ($urandom_range(299) == 0);
            ciclo();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
